// File: rtl/stdaes_key_scheduler_if.sv
// stdaes_key_scheduler_if: key load/advance handshake and round-key outputs
interface stdaes_key_scheduler_if;
    logic [127:0] kin;
    logic         krdy;
    logic         knext;
    logic [127:0] kout;
    logic         kvld;
    logic [3:0]   round;
    logic [1:0]   sel;
    logic         done;
    modport master (output kin, krdy, knext, input kout, kvld, round, sel, done);
    modport slave  (input kin, krdy, knext, output kout, kvld, round, sel, done);
endinterface

// File: rtl/stdaes_key_scheduler.sv
// stdaes_key_scheduler: AES-128 on-the-fly key expansion, one round key per step
module stdaes_key_scheduler #(
    parameter int NR = 10
) (
    input logic                   CLK,
    input logic                   RSTn,
    stdaes_key_scheduler_if.slave kif
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam logic [3:0] LAST = 4'(NR);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    function automatic logic [7:0] sub(input logic [7:0] b);
        return SBOX[b];
    endfunction
    logic [127:0] r_key;
    logic [3:0]   r_round;
    logic [7:0]   r_rcon;
    logic [0:0]   r_state;
    logic [1:0]   r_sel;
    logic         r_done;
    logic [31:0]  w_rot, w_t, w_n0, w_n1, w_n2, w_n3;
    logic [7:0]   w_xt;
    logic [3:0]   w_rnext;
    logic         w_step;
    always_comb begin
        w_rot   = {r_key[23:0], r_key[31:24]};
        w_t     = {sub(w_rot[31:24]) ^ r_rcon, sub(w_rot[23:16]), sub(w_rot[15:8]), sub(w_rot[7:0])};
        w_n0    = r_key[127:96] ^ w_t;
        w_n1    = r_key[95:64] ^ w_n0;
        w_n2    = r_key[63:32] ^ w_n1;
        w_n3    = r_key[31:0] ^ w_n2;
        w_xt    = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
        w_rnext = r_round + 4'd1;
        w_step  = kif.knext && (r_state == RUN) && (r_round != LAST);
    end
    // krdy wins over knext so a reload always restarts the schedule at round 0
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_key   <= '0;
            r_round <= '0;
            r_rcon  <= 8'h01;
            r_state <= IDLE;
            r_sel   <= 2'b00;
            r_done  <= 1'b0;
        end else if (kif.krdy) begin
            r_key   <= kif.kin;
            r_round <= '0;
            r_rcon  <= 8'h01;
            r_state <= RUN;
            r_sel   <= 2'b00;
            r_done  <= 1'b0;
        end else if (w_step) begin
            r_key   <= {w_n0, w_n1, w_n2, w_n3};
            r_round <= w_rnext;
            r_rcon  <= w_xt;
            r_sel   <= (w_rnext == LAST) ? 2'b10 : 2'b01;
            r_done  <= (w_rnext == LAST);
        end
    end
    assign kif.kout  = r_key;
    assign kif.kvld  = (r_state == RUN);
    assign kif.round = r_round;
    assign kif.sel   = r_sel;
    assign kif.done  = r_done;
endmodule

// File: tb/tb_stdaes_key_scheduler.sv
// tb_stdaes_key_scheduler: directed and random checks against a full-table key expansion model
module tb_stdaes_key_scheduler;
    logic CLK;
    logic RSTn;
    stdaes_key_scheduler_if kif ();
    stdaes_key_scheduler #(.NR(10)) dut (.CLK(CLK), .RSTn(RSTn), .kif(kif));
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    localparam logic [127:0] KA  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KA1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KA10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KB  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KB10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    int n_vec = 0;
    int n_err = 0;
    logic [7:0]   sb [0:255];
    logic [127:0] m_keys [0:10];
    logic         m_vld;
    int           m_rnd;
    function automatic logic [7:0] gmul(input logic [7:0] a0, input logic [7:0] b0);
        logic [7:0] a, b, p;
        a = a0; b = b0; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction
    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction
    // S-box from the GF(2^8) inverse plus affine map, independent of any lookup table
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask
    task automatic expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]] ^ rc, sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) m_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask
    task automatic cycle(input logic rn, input logic kr, input logic kn, input logic [127:0] k);
        RSTn = rn; kif.krdy = kr; kif.knext = kn; kif.kin = k;
        @(posedge CLK);
        if (!rn) begin
            m_vld = 1'b0; m_rnd = 0;
        end else if (kr) begin
            expand(k); m_vld = 1'b1; m_rnd = 0;
        end else if (kn && m_vld && m_rnd < 10) m_rnd++;
        #1;
        chk("kout", kif.kout, m_vld ? m_keys[m_rnd] : 128'h0);
        chk("kvld", 128'(kif.kvld), 128'(m_vld));
        chk("round", 128'(kif.round), 128'(m_rnd));
        chk("sel", 128'(kif.sel), (m_rnd == 0) ? 128'd0 : (m_rnd == 10) ? 128'd2 : 128'd1);
        chk("done", 128'(kif.done), 128'(m_vld && m_rnd == 10));
    endtask
    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction
    initial begin
        logic [127:0] kr, hold;
        build_sbox();
        m_vld = 1'b0; m_rnd = 0;
        RSTn = 1'b0; kif.krdy = 1'b1; kif.knext = 1'b1; kif.kin = KA;
        cycle(1'b0, 1'b1, 1'b1, rnd128());
        cycle(1'b0, 1'b1, 1'b1, rnd128());
        cycle(1'b1, 1'b1, 1'b0, KA);
        chk("a_r0", kif.kout, KA);
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1, 1'b0, 1'b1, rnd128());
            if (i == 1) chk("a_r1", kif.kout, KA1);
            cycle(1'b1, 1'b0, 1'b0, rnd128());
        end
        chk("a_r10", kif.kout, KA10);
        cycle(1'b1, 1'b1, 1'b0, KB);
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 1'b0, 1'b1, rnd128());
            if (i == 9) chk("b_r10", kif.kout, KB10);
        end
        chk("b_hold", kif.kout, KB10);
        cycle(1'b1, 1'b1, 1'b0, rnd128());
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1, rnd128());
        cycle(1'b1, 1'b1, 1'b1, KA);
        chk("reload_r0", kif.kout, KA);
        cycle(1'b1, 1'b0, 1'b1, rnd128());
        chk("reload_r1", kif.kout, KA1);
        cycle(1'b0, 1'b0, 1'b0, rnd128());
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b1, rnd128());
            cycle(1'b1, 1'b0, 1'b0, rnd128());
        end
        cycle(1'b1, 1'b1, 1'b0, KB);
        cycle(1'b1, 1'b0, 1'b1, rnd128());
        cycle(1'b1, 1'b1, 1'b0, rnd128());
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b1, rnd128());
        cycle(1'b0, 1'b0, 1'b1, rnd128());
        kr = rnd128();
        cycle(1'b1, 1'b1, 1'b0, kr);
        cycle(1'b1, 1'b0, 1'b1, rnd128());
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, rnd128());
        hold = rnd128();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) hold = rnd128();
            cycle($urandom_range(0, 60) != 0, $urandom_range(0, 12) == 0, $urandom_range(0, 2) != 0, hold);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
